// File: rtl/demux1_2_pair.sv
// demux1_2_pair: rebuilds A/B word pairs from a sel-tagged muxed stream
// and presents each completed pair on a valid/ready output handshake.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   in_valid      input word valid
//   sel           channel tag of din (0 = A, 1 = B)
//   din[w:1]      muxed data word
//   in_ready      word accepted this cycle (comb, low in reset)
//   out_ready     downstream consumes the pair this cycle
//   out_valid     outA/outB hold a complete pair
//   outA, outB    recovered channel words
//   seq_err       one-cycle pulse on a tag-order violation
//   pair_cnt[7:0] pairs delivered, wraps 255 -> 0
module demux1_2_pair #(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         sel,
  input  logic [w:1]   din,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [w:1]   outA,
  output logic [w:1]   outB,
  output logic         seq_err,
  output logic [7:0]   pair_cnt
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t state;

  logic is_full;
  logic acc;
  logic acc_a;
  logic acc_b;
  logic dlv;

  assign is_full = (state == FULL);

  // In FULL a new word can only enter on the edge
  // that also drains the pending pair.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = is_full ? out_ready : 1'b1;
    end
  end

  assign acc   = in_valid && in_ready;
  assign acc_a = acc && !sel;
  assign acc_b = acc && sel;
  assign dlv   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
      pair_cnt  <= 8'd0;
      outA      <= '0;
      outB      <= '0;
    end else begin
      seq_err <= 1'b0;
      unique case (1'b1)
        (state == EMPTY): begin
          if (acc_a) begin
            outA  <= din;
            state <= HAVE_A;
          end else if (acc_b) begin
            seq_err <= 1'b1;
          end
        end
        (state == HAVE_A): begin
          if (acc_b) begin
            outB      <= din;
            out_valid <= 1'b1;
            state     <= FULL;
          end else if (acc_a) begin
            outA    <= din;
            seq_err <= 1'b1;
          end
        end
        (state == FULL): begin
          if (dlv) begin
            pair_cnt  <= pair_cnt + 8'd1;
            out_valid <= 1'b0;
            state     <= EMPTY;
            if (acc_a) begin
              outA  <= din;
              state <= HAVE_A;
            end else if (acc_b) begin
              seq_err <= 1'b1;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux1_2_pair.sv
// tb_demux1_2_pair: directed checks of pairing, back-pressure,
// order errors, counter wrap and asynchronous reset.
module tb_demux1_2_pair;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       sel;
  logic [4:1] din;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [4:1] outA;
  logic [4:1] outB;
  logic       seq_err;
  logic [7:0] pair_cnt;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_cnt;

  demux1_2_pair #(.w(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sel       (sel),
    .din       (din),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .outA      (outA),
    .outB      (outB),
    .seq_err   (seq_err),
    .pair_cnt  (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [4:1] d);
    in_valid = v;
    sel      = s;
    din      = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0);
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'd9);
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, seq_err, pair_cnt, outA, outB, in_ready} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset v=%b e=%b cnt=%0d a=%0d b=%0d rdy=%b want all 0",
               out_valid, seq_err, pair_cnt, outA, outB, in_ready);
    end
    drive(1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_rdy in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd3);
    tick();
    n_cmp++;
    if ({out_valid, seq_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL stream_e1 v/e=%b%b want 00", out_valid, seq_err);
    end
    drive(1'b1, 1'b1, 4'd5);
    tick();
    n_cmp++;
    if ({out_valid, outA, outB, seq_err} !== {1'b1, 4'd3, 4'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL stream_p1 v=%b a=%0d b=%0d e=%b want 1 3 5 0",
               out_valid, outA, outB, seq_err);
    end
    drive(1'b1, 1'b0, 4'd7);
    tick();
    exp_cnt++;
    n_cmp++;
    if ({out_valid, seq_err, pair_cnt} !== {1'b0, 1'b0, exp_cnt}) begin
      n_bad++;
      $display("FAIL stream_e3 v=%b e=%b cnt=%0d want 0 0 %0d",
               out_valid, seq_err, pair_cnt, exp_cnt);
    end
    drive(1'b1, 1'b1, 4'd9);
    tick();
    n_cmp++;
    if ({out_valid, outA, outB, seq_err} !== {1'b1, 4'd7, 4'd9, 1'b0}) begin
      n_bad++;
      $display("FAIL stream_p2 v=%b a=%0d b=%0d e=%b want 1 7 9 0",
               out_valid, outA, outB, seq_err);
    end
    drive(1'b0, 1'b0, 4'd0);
    tick();
    exp_cnt++;
    n_cmp++;
    if ({out_valid, seq_err, pair_cnt} !== {1'b0, 1'b0, 8'd2}) begin
      n_bad++;
      $display("FAIL stream_end v=%b e=%b cnt=%0d want 0 0 2",
               out_valid, seq_err, pair_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd1);
    tick();
    drive(1'b1, 1'b1, 4'd2);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd4);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_rdy in_ready=%b want 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, outA, outB, seq_err, in_ready, pair_cnt}
          !== {1'b1, 4'd1, 4'd2, 1'b0, 1'b0, exp_cnt}) begin
        n_bad++;
        $display("FAIL bp_hold%0d v=%b a=%0d b=%0d e=%b r=%b cnt=%0d want 1 1 2 0 0 %0d",
                 i, out_valid, outA, outB, seq_err, in_ready, pair_cnt, exp_cnt);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_rdy in_ready=%b want 1", in_ready);
    end
    tick();
    exp_cnt++;
    n_cmp++;
    if ({out_valid, outA, seq_err, pair_cnt} !== {1'b0, 4'd4, 1'b0, exp_cnt}) begin
      n_bad++;
      $display("FAIL bp_release v=%b a=%0d e=%b cnt=%0d want 0 4 0 %0d",
               out_valid, outA, seq_err, pair_cnt, exp_cnt);
    end
    drive(1'b1, 1'b1, 4'd8);
    tick();
    n_cmp++;
    if ({out_valid, outA, outB, seq_err} !== {1'b1, 4'd4, 4'd8, 1'b0}) begin
      n_bad++;
      $display("FAIL bp_next v=%b a=%0d b=%0d e=%b want 1 4 8 0",
               out_valid, outA, outB, seq_err);
    end
    drive(1'b0, 1'b0, 4'd0);
    tick();
    exp_cnt++;
  endtask

  task automatic test_order_err();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 4'd6);
    tick();
    n_cmp++;
    if ({seq_err, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL oe_b_first e/v=%b%b want 10", seq_err, out_valid);
    end
    drive(1'b0, 1'b0, 4'd0);
    tick();
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oe_pulse_len seq_err=%b want 0", seq_err);
    end
    drive(1'b1, 1'b0, 4'd1);
    tick();
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oe_a1 seq_err=%b want 0", seq_err);
    end
    drive(1'b1, 1'b0, 4'd2);
    tick();
    n_cmp++;
    if ({seq_err, out_valid, outA} !== {1'b1, 1'b0, 4'd2}) begin
      n_bad++;
      $display("FAIL oe_a2 e=%b v=%b a=%0d want 1 0 2", seq_err, out_valid, outA);
    end
    drive(1'b1, 1'b1, 4'd3);
    tick();
    n_cmp++;
    if ({seq_err, out_valid, outA, outB} !== {1'b0, 1'b1, 4'd2, 4'd3}) begin
      n_bad++;
      $display("FAIL oe_pair e=%b v=%b a=%0d b=%0d want 0 1 2 3",
               seq_err, out_valid, outA, outB);
    end
    drive(1'b0, 1'b0, 4'd0);
    tick();
    exp_cnt++;
  endtask

  task automatic test_deliver_wrong_tag();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd10);
    tick();
    drive(1'b1, 1'b1, 4'd11);
    tick();
    drive(1'b1, 1'b1, 4'd12);
    tick();
    exp_cnt++;
    n_cmp++;
    if ({seq_err, out_valid, pair_cnt} !== {1'b1, 1'b0, exp_cnt}) begin
      n_bad++;
      $display("FAIL dw_pulse e=%b v=%b cnt=%0d want 1 0 %0d",
               seq_err, out_valid, pair_cnt, exp_cnt);
    end
    drive(1'b1, 1'b0, 4'd13);
    tick();
    n_cmp++;
    if ({seq_err, out_valid, outA} !== {1'b0, 1'b0, 4'd13}) begin
      n_bad++;
      $display("FAIL dw_empty e=%b v=%b a=%0d want 0 0 13", seq_err, out_valid, outA);
    end
    drive(1'b1, 1'b1, 4'd14);
    tick();
    n_cmp++;
    if ({out_valid, outA, outB} !== {1'b1, 4'd13, 4'd14}) begin
      n_bad++;
      $display("FAIL dw_next v=%b a=%0d b=%0d want 1 13 14", out_valid, outA, outB);
    end
    drive(1'b0, 1'b0, 4'd0);
    tick();
    exp_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 1; p <= 257; p++) begin
      drive(1'b1, 1'b0, 4'(p));
      tick();
      drive(1'b1, 1'b1, 4'(p + 1));
      tick();
      drive(1'b0, 1'b0, 4'd0);
      tick();
      exp_cnt++;
      if (p >= 255) begin
        n_cmp++;
        if (pair_cnt !== exp_cnt) begin
          n_bad++;
          $display("FAIL wrap_p%0d pair_cnt=%0d want %0d", p, pair_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd5);
    tick();
    drive(1'b0, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, outA, in_ready, pair_cnt, seq_err} !== 15'd0) begin
      n_bad++;
      $display("FAIL ar_have_a v=%b a=%0d r=%b cnt=%0d e=%b want all 0",
               out_valid, outA, in_ready, pair_cnt, seq_err);
    end
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    drive(1'b1, 1'b0, 4'd5);
    tick();
    drive(1'b1, 1'b1, 4'd6);
    tick();
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, outA, outB, in_ready, pair_cnt, seq_err} !== 19'd0) begin
      n_bad++;
      $display("FAIL ar_full v=%b a=%0d b=%0d r=%b cnt=%0d e=%b want all 0",
               out_valid, outA, outB, in_ready, pair_cnt, seq_err);
    end
    tick();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, seq_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL ar_idle v=%b e=%b want 0 0", out_valid, seq_err);
    end
    drive(1'b1, 1'b0, 4'd7);
    tick();
    drive(1'b1, 1'b1, 4'd8);
    tick();
    n_cmp++;
    if ({out_valid, outA, outB, seq_err, pair_cnt} !== {1'b1, 4'd7, 4'd8, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL ar_new_pair v=%b a=%0d b=%0d e=%b cnt=%0d want 1 7 8 0 0",
               out_valid, outA, outB, seq_err, pair_cnt);
    end
    drive(1'b0, 1'b0, 4'd0);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = 8'd0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0);
    test_reset();
    test_stream();
    test_backpressure();
    test_order_err();
    test_deliver_wrong_tag();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
